// File: rtl/sobel_stream_framer_if.sv
// Stream bundle around the sobel output framer: upstream pixel stream in,
// framed video stream out, plus frame status.
interface sobel_stream_framer_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pixel_i;
  logic        last_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        m_user_o;
  logic        m_last_o;
  logic        frame_err_o;
  logic [15:0] frame_cnt_o;

  modport slave (
    input  valid_i, pixel_i, last_i, m_ready_i,
    output ready_o, m_valid_o, m_data_o, m_user_o, m_last_o, frame_err_o, frame_cnt_o
  );

  modport master (
    output valid_i, pixel_i, last_i, m_ready_i,
    input  ready_o, m_valid_o, m_data_o, m_user_o, m_last_o, frame_err_o, frame_cnt_o
  );
endinterface

// File: rtl/sobel_stream_framer.sv
// Re-frames the sobel pixel stream with start-of-frame / end-of-line markers,
// checks the upstream end-of-frame flag and counts frames.
module sobel_stream_framer #(
  parameter int WIDTH_P  = 640,
  parameter int HEIGHT_P = 480
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  sobel_stream_framer_if.slave  s
);
  localparam int XW = $clog2(WIDTH_P);
  localparam int YW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH_P - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT_P - 1);

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  beat_t         out_q, out_d, skid_q, skid_d, in_beat;
  logic          out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ready, acc, xfer, final_px, early_end;

  // ready depends only on the skid flop (and reset), never on m_ready_i
  assign ready = reset_i && !skid_v_q;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;

    acc       = s.valid_i && ready;
    xfer      = out_v_q && s.m_ready_i;
    final_px  = (x_q == X_LAST) && (y_q == Y_LAST);
    early_end = s.last_i && !final_px;

    in_beat.data = s.pixel_i;
    in_beat.user = (x_q == '0) && (y_q == '0);
    in_beat.last = (x_q == X_LAST) || early_end;

    if (!out_v_q || xfer) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = acc;
        if (acc) out_d = in_beat;
      end
    end else if (acc) begin
      skid_d   = in_beat;
      skid_v_d = 1'b1;
    end

    if (acc) begin
      if (early_end) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // any frame end (clean, early or missing last) closes a frame
    err_d = acc && (s.last_i != final_px);
    if (acc && (s.last_i || final_px)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s.ready_o     = ready;
  assign s.m_valid_o   = out_v_q;
  assign s.m_data_o    = out_q.data;
  assign s.m_user_o    = out_q.user;
  assign s.m_last_o    = out_q.last;
  assign s.frame_err_o = err_q;
  assign s.frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_sobel_stream_framer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_sobel_stream_framer;
  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_stream_framer_if io0 ();
  sobel_stream_framer_if io1 ();

  sobel_stream_framer #(.WIDTH_P(4), .HEIGHT_P(2)) dut0 (.clk_i(clk), .reset_i(rst_n), .s(io0));
  sobel_stream_framer #(.WIDTH_P(2), .HEIGHT_P(1)) dut1 (.clk_i(clk), .reset_i(rst_n), .s(io1));

  int    checks = 0;
  int    errors = 0;
  int    err_cnt = 0;
  int    drops = 0;
  beat_t q[$];
  beat_t got, exp_b, prev;
  bit    prev_stall = 0;
  bit    tog_en = 0;
  int    tog_i = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // downstream backpressure pattern 1,0,0,1
  always @(posedge clk) begin
    if (tog_en) begin
      #1;
      io0.m_ready_i = (tog_i % 4 == 0) || (tog_i % 4 == 3);
      tog_i++;
    end
  end

  always @(negedge clk) begin
    if (io1.frame_err_o === 1'b1 && 0) err_cnt = err_cnt;
    if (io0.frame_err_o) err_cnt++;
    if (!rst_n) prev_stall = 0;
    else begin
      got = '{data: io0.m_data_o, user: io0.m_user_o, last: io0.m_last_o};
      if (prev_stall) begin
        chk("hold_valid", 64'(io0.m_valid_o), 64'd1);
        chk("hold_beat", 64'(got), 64'(prev));
      end
      if (!io0.ready_o) begin
        drops++;
        chk("ready_low_out_full", 64'(io0.m_valid_o), 64'd1);
      end
      if (io0.m_valid_o && io0.m_ready_i) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat got %0h want none", got);
        end else begin
          exp_b = q.pop_front();
          chk("beat", 64'(got), 64'(exp_b));
        end
      end
      prev_stall = io0.m_valid_o && !io0.m_ready_i;
      prev = got;
    end
  end

  // called at the drive point (1 unit after posedge); returns at the next drive point after accept
  task automatic send(input logic [31:0] d, input logic l, input logic eu, input logic el);
    int t = 0;
    io0.valid_i = 1'b1;
    io0.pixel_i = d;
    io0.last_i  = l;
    @(negedge clk);
    while (!io0.ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!io0.ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready 0 want 1 pixel %0d", d);
    end else q.push_back('{data: d, user: eu, last: el});
    @(posedge clk);
    #1;
    io0.valid_i = 1'b0;
    io0.last_i  = 1'b0;
  endtask

  task automatic send_seq(input int base, input int n, input logic [15:0] lin,
                          input logic [15:0] uexp, input logic [15:0] lexp);
    for (int i = 0; i < n; i++) send(32'(base + i), lin[i], uexp[i], lexp[i]);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, db;
    io0.valid_i = 0; io0.pixel_i = 0; io0.last_i = 0; io0.m_ready_i = 1;
    io1.valid_i = 0; io1.pixel_i = 0; io1.last_i = 0; io1.m_ready_i = 1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(io0.m_valid_o), 0);
    chk("rst_user",  64'(io0.m_user_o), 0);
    chk("rst_last",  64'(io0.m_last_o), 0);
    chk("rst_data",  64'(io0.m_data_o), 0);
    chk("rst_err",   64'(io0.frame_err_o), 0);
    chk("rst_cnt",   64'(io0.frame_cnt_o), 0);
    chk("rst_ready", 64'(io0.ready_o), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(io0.ready_o), 1);

    // T1: back-to-back full frame
    eb = err_cnt;
    for (int i = 0; i < 8; i++) begin
      send(32'(i), i == 7, i == 0, (i == 3) || (i == 7));
      if (i == 0) begin
        chk("lat_valid", 64'(io0.m_valid_o), 1);
        chk("lat_data",  64'(io0.m_data_o), 0);
      end
    end
    drain();
    chk("t1_cnt", 64'(io0.frame_cnt_o), 1);
    chk("t1_err", 64'(err_cnt - eb), 0);

    // T2: same frame under 1,0,0,1 backpressure
    eb = err_cnt;
    db = drops;
    tog_i = 0;
    tog_en = 1;
    send_seq(100, 8, 16'h0080, 16'h0001, 16'h0088);
    drain();
    tog_en = 0;
    @(posedge clk);
    #2;
    io0.m_ready_i = 1;
    drain();
    chk("t2_cnt", 64'(io0.frame_cnt_o), 2);
    chk("t2_err", 64'(err_cnt - eb), 0);
    chk("t2_skid_used", 64'(drops > db), 1);

    // T3: early last on pixel 5, then a clean frame
    eb = err_cnt;
    send_seq(200, 6, 16'h0020, 16'h0001, 16'h0028);
    drain();
    chk("t3_err", 64'(err_cnt - eb), 1);
    chk("t3_cnt", 64'(io0.frame_cnt_o), 3);
    eb = err_cnt;
    send_seq(210, 8, 16'h0080, 16'h0001, 16'h0088);
    drain();
    chk("t3b_err", 64'(err_cnt - eb), 0);
    chk("t3b_cnt", 64'(io0.frame_cnt_o), 4);

    // T4: missing last, then a clean frame
    eb = err_cnt;
    send_seq(300, 8, 16'h0000, 16'h0001, 16'h0088);
    drain();
    chk("t4_err", 64'(err_cnt - eb), 1);
    chk("t4_cnt", 64'(io0.frame_cnt_o), 5);
    eb = err_cnt;
    send_seq(310, 8, 16'h0080, 16'h0001, 16'h0088);
    drain();
    chk("t4b_err", 64'(err_cnt - eb), 0);
    chk("t4b_cnt", 64'(io0.frame_cnt_o), 6);

    // T5: reset mid-frame with output stalled
    eb = err_cnt;
    io0.m_ready_i = 0;
    send(400, 0, 1, 0);
    send(401, 0, 0, 0);
    chk("t5_skid_ready", 64'(io0.ready_o), 0);
    chk("t5_out_data",   64'(io0.m_data_o), 400);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    rst_n = 1'b1;
    #1;
    chk("t5_valid", 64'(io0.m_valid_o), 0);
    chk("t5_cnt",   64'(io0.frame_cnt_o), 0);
    chk("t5_ready", 64'(io0.ready_o), 1);
    io0.m_ready_i = 1;
    send(410, 0, 1, 0);
    drain();
    chk("t5_err", 64'(err_cnt - eb), 0);

    // T6: counter wrap on 2x1 frames; 65535 one-pixel early frames then a clean one
    io1.valid_i = 1;
    io1.last_i  = 1;
    io1.pixel_i = 32'h55;
    repeat (65535) @(posedge clk);
    #1;
    chk("t6_cnt_ffff", 64'(io1.frame_cnt_o), 64'hFFFF);
    chk("t6_err_early", 64'(io1.frame_err_o), 1);
    io1.last_i = 0;
    @(posedge clk);
    #1;
    chk("t6_a_err",  64'(io1.frame_err_o), 0);
    chk("t6_a_user", 64'(io1.m_user_o), 1);
    chk("t6_a_last", 64'(io1.m_last_o), 0);
    io1.last_i = 1;
    @(posedge clk);
    #1;
    io1.valid_i = 0;
    chk("t6_wrap_cnt", 64'(io1.frame_cnt_o), 0);
    chk("t6_wrap_err", 64'(io1.frame_err_o), 0);
    chk("t6_b_user",   64'(io1.m_user_o), 0);
    chk("t6_b_last",   64'(io1.m_last_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
